// File: rtl/mux_sched_pkg.sv
// Shared types, sizes and one-hot/index helpers for the 8:1 mux select scheduler.
package mux_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = IDLE,
    S_GRANT = GRANT
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | SEL_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Request/grant bundle between the requesters and the mux select scheduler.
interface mux_sel_scheduler_if;
  import mux_sched_pkg::*;

  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               busy;

  modport master (
    output enable, req,
    input  grant, sel, sel_valid, busy
  );

  modport slave (
    input  enable, req,
    output grant, sel, sel_valid, busy
  );
endinterface

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 7 -> 0.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_found
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Rotating the doubled vector puts the ptr position at bit 0
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NUM_REQ];

  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = SEL_W'(j);
      end else begin
        w_off = w_off;
      end
    end
  end

  assign o_idx   = i_ptr + w_off;
  assign o_found = |i_req;

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin owner selection for the shared 8:1 mux; registered one-hot grant and select.
// Optional burst limit is enabled by defining MUX_SEL_SCHEDULER_BURST_LIMIT_EN.
module mux_sel_scheduler
  import mux_sched_pkg::*;
`ifdef MUX_SEL_SCHEDULER_BURST_LIMIT_EN
#(
  parameter int MAX_BURST = 16,
  parameter int BCNT_W    = 8
)
`endif
(
  input logic           clk,
  input logic           rst,
  mux_sel_scheduler_if.slave bus
);

  state_e             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic [SEL_W-1:0]   w_idx;
  logic               w_found;
  logic               w_release;
  logic               w_issue;
  logic               w_burst_hit;

  // While granted, the next winner is searched from just above the current owner
  assign w_pick_ptr = (r_state == S_GRANT) ? (r_sel + 3'd1) : r_ptr;

  rr_pick u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (w_pick_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_release = (r_state == S_GRANT) && (!bus.req[r_sel] || w_burst_hit);

`ifdef MUX_SEL_SCHEDULER_BURST_LIMIT_EN
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;

  assign w_burst_hit = (r_bcnt == BCNT_W'(MAX_BURST));

  always_comb begin
    w_bcnt_nxt = r_bcnt;
    if (w_issue) begin
      w_bcnt_nxt = {{(BCNT_W-1){1'b0}}, 1'b1};
    end else if ((r_state == S_GRANT) && (r_bcnt != {BCNT_W{1'b1}})) begin
      w_bcnt_nxt = r_bcnt + {{(BCNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_bcnt_nxt = r_bcnt;
    end
  end

  // Burst counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt <= '0;
    end else begin
      r_bcnt <= w_bcnt_nxt;
    end
  end
`else
  assign w_burst_hit = 1'b0;
`endif

  // Next-state and next grant/select/pointer
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable && w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = idx_to_onehot(w_idx);
          w_sel_nxt   = w_idx;
          w_issue     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_sel + 3'd1;
          if (bus.enable && w_found) begin
            w_state_nxt = S_GRANT;
            w_grant_nxt = idx_to_onehot(w_idx);
            w_sel_nxt   = w_idx;
            w_issue     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant, select and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.sel_valid = (r_state == S_GRANT);
  assign bus.busy      = (r_state == S_GRANT);

endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
- Round-robin scheduler that shares the team's 8:1 single-bit multiplexer between 8 requesters.
- Arbitrates among request lines and issues a registered one-hot grant.
- Drives the mux's 3-bit select with the granted index and flags when that select is valid.
- Sits directly in front of the 8:1 mux; the select output connects straight to the mux select input.

Parameters:
- MAX_BURST, 16, maximum consecutive cycles one owner may hold the grant (legal range 1..255); used only when BURST_LIMIT_EN is defined.
- BCNT_W, 8, burst counter width; must satisfy 2**BCNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = new grants may be issued.
- req  input  8  request vector; req[i] high = requester i wants mux input I[i] routed.
- grant  output  8  registered one-hot grant, or all zero.
- sel  output  3  mux select = index of the granted requester.
- sel_valid  output  1  high while grant is nonzero.
- busy  output  1  high when state is GRANT.

Behaviour:
- Reset values (rst sampled high at a rising edge): state=IDLE, grant=0, sel=0, sel_valid=0, busy=0, ptr=0, burst count=0.
- Reset has priority over every other event, including mid-grant; the grant drops on the next edge.
- State IDLE:
  - If enable=1 and req is nonzero, pick the winner with the round-robin picker.
  - Next edge: state=GRANT, grant=onehot(k), sel=k, sel_valid=1, burst count=1.
  - Latency from req to grant is 1 cycle.
- State GRANT with owner k: release occurs when req[k]=0 is sampled. With BURST_LIMIT_EN, release also occurs when burst count==MAX_BURST.
- On release:
  - ptr <= (k+1) mod 8.
  - If enable=1 and any req is high, the new winner is granted on the same edge (no bubble, burst count=1). The winner is picked from ptr=(k+1) mod 8, so the old owner is re-granted only if it is the sole requester.
  - Otherwise the block goes to IDLE: grant=0, sel_valid=0, and sel keeps its last value.
- Without a release: grant and sel hold, and burst count increments, saturating at 2**BCNT_W-1.
- Round-robin rule: the winner is the first set bit of req searching upward from ptr, wrapping 7->0. ptr changes only on a release.
- enable=0 during GRANT: the current owner keeps the grant until release, then the block goes to IDLE. enable is ignored during reset.
- req changes on non-owner lines during GRANT have no effect until the next release.
- busy equals sel_valid (state==GRANT).

Optional Feature:
- Macro: MUX_SEL_SCHEDULER_BURST_LIMIT_EN.
- Defined: burst counter active; an owner is forced to release after MAX_BURST cycles even with req still high.
- Undefined: no burst counter logic; an owner holds the grant until its req drops, and MAX_BURST/BCNT_W are unused.

Decomposition:
- Shared package mux_sched_pkg holds:
  - NUM_REQ=8 and SEL_W=3.
  - State encoding localparams IDLE=1'b0, GRANT=1'b1.
  - The onehot/index conversion function.
- One combinational sub-module rr_pick:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], found.
  - Contains the wrap-around priority search.
- The top level holds the state register, grant/sel registers, ptr and burst counter.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, enable=1 -> grant=0, sel=0, sel_valid=0. The first edge after rst=0 -> grant=8'h01, sel=0.
- Single owner: req=8'h20 from cycle 10 to cycle 14, then 0 -> grant=8'h20, sel=5 on cycles 11-15. Cycle 16: grant=0, sel_valid=0, sel stays 5.
- Fair rotation, macro undefined: req=8'hFF; each owner drops req the cycle after it is granted -> grants 0,1,2,...,7,0 in order with no idle cycles.
- Burst limit, macro defined, MAX_BURST=4, req=8'h81 held -> grant 8'h01 for 4 cycles, 8'h80 for 4, 8'h01 for 4, with no gaps. Same stimulus with macro undefined -> 8'h01 held indefinitely.
- Enable and mid-grant reset:
  - Owner 3 granted, then enable=0 -> grant 8'h08 persists until req[3] drops, then IDLE even with req=8'h10.
  - With owner 3 granted, rst=1 for one cycle -> next edge grant=0, ptr=0.
